partoserial_tx: RTL and testbench
=================================

// Module: partoserial_tx
// PURPOSE
// - Transmit side of the PHY serial link. Converts 8-bit parallel words into an MSB-first serial bit stream, one bit per clk_8f cycle.
// - Sends comma words (8'hBC) for link training after reset, and as idle fill whenever no word is offered.
// - Feeds the phy_rx serial-to-parallel receiver. That receiver locks after 4 commas and flags every non-comma word as valid.
// PARAMETERS
// - IDLE_WORD  8'hBC  comma/idle word, used for training and as fill
// - MIN_BC     4      comma words sent after reset before data is accepted (1..15)
// PORTS
// - clk_8f     in   1  bit clock, the only clock; all logic on posedge
// - reset      in   1  asynchronous, active-high reset
// - data_par   in   8  parallel word to send
// - valid_par  in   1  data_par holds a word to send
// - ready_par  out  1  word slot open; data_par is taken on this edge when valid_par=1
// - data_out   out  1  serial output, MSB first
// - trained    out  1  high once MIN_BC training commas have been loaded
// - word_start out  1  high while data_out carries bit 7 of a word
// - idle_out   out  1  high while the word on data_out is a fill comma (in TRAIN or in ACTIVE)
// BEHAVIOUR
// - Registers: shift_reg[7:0], bit_cnt[2:0], bc_cnt[3:0], state{TRAIN,ACTIVE}, data_out, idle_out.
// - Reset (asynchronous, held while reset=1): data_out=0, shift_reg=0, bit_cnt=7, bc_cnt=0, state=TRAIN, idle_out=1.
// - Combinational outputs: trained=(state==ACTIVE); word_start=(bit_cnt==0); ready_par=(state==ACTIVE)&&(bit_cnt==7).
// - Load edge: an edge where bit_cnt==7. The first edge after reset release is a load edge.
//   - next_word = (ready_par && valid_par) ? data_par : IDLE_WORD.
//   - data_out<=next_word[7]; shift_reg<={next_word[6:0],1'b0}; bit_cnt<=0.
//   - idle_out<=!(ready_par && valid_par).
// - Other edges: data_out<=shift_reg[7]; shift_reg<=shift_reg<<1; bit_cnt<=bit_cnt+1.
// - Word period is exactly 8 cycles, with no gaps and no stalls. A comma is always transmitted in full.
// - Latency: a word accepted at load edge E drives bit7 on data_out after E, and bit0 after E+7.
// - TRAIN state:
//   - ready_par=0 and valid_par is ignored.
//   - Each load edge loads IDLE_WORD and increments bc_cnt.
//   - The load edge that makes bc_cnt==MIN_BC moves state to ACTIVE. ready_par is therefore first high at the last bit of comma #MIN_BC.
// - ACTIVE state:
//   - Stays in ACTIVE until reset.
//   - valid_par=0 at a load edge sends IDLE_WORD; no word is lost and none is held.
//   - bc_cnt saturates and is unused.
// - Handshake: the word is accepted only when ready_par&&valid_par, and only on that edge. The upstream must hold data_par/valid_par until acceptance.
//   - valid_par changes while ready_par=0 have no effect.
// - data_par==IDLE_WORD with valid_par=1 is sent as-is with idle_out=0. The receiver treats it as a comma; this is the caller's responsibility.
// - Reset mid-word: the serial output goes to 0 immediately. After release the block retrains with MIN_BC full commas, and the partial word is discarded.
// - Bit order matches the receiver: the first bit sent lands in the receiver MSB after 8 shifts.
// TESTING
// - Reset release, valid_par=0:
//   - data_out is 32 bits of 1011_1100 repeated.
//   - trained rises on edge 25, and ready_par is first 1 on cycle 32.
// - After training, offer 8'hA5 with valid_par held:
//   - Accepted on the first ready_par.
//   - Next 8 bits are 1,0,1,0,0,1,0,1 with idle_out=0.
//   - Then 8'hBC fill with idle_out=1.
// - Back-to-back words 8'h01, 8'hFF, 8'h3C with valid_par always 1:
//   - Contiguous 24-bit stream with no fill.
//   - ready_par pulses every 8 cycles.
// - Assert reset at bit 3 of a data word:
//   - data_out=0 and trained=0 asynchronously.
//   - After release, 4 full commas precede any data.
// - Loopback into the phy_rx serial-to-parallel receiver, words 8'h11..8'h20:
//   - The receiver outputs the same 16 words in order, each with valid_par=1.
// - valid_par toggled between load edges:
//   - Only the values at load edges matter.
//   - No word is duplicated or dropped.

Source files
------------

// File: rtl/partoserial_tx_if.sv
// Parallel word handshake into the serial transmitter.
// The master offers data_par/valid_par; the slave answers with ready_par.
interface partoserial_tx_if;
  logic [7:0] data_par;
  logic       valid_par;
  logic       ready_par;

  modport master (
    output data_par,
    output valid_par,
    input  ready_par
  );

  modport slave (
    input  data_par,
    input  valid_par,
    output ready_par
  );
endinterface

// File: rtl/partoserial_tx.sv
// PHY serial link transmitter: 8-bit words out MSB first, one bit per clk_8f.
// Sends comma training words after reset and comma fill whenever idle.
module partoserial_tx #(
  parameter logic [7:0]  IDLE_WORD = 8'hBC,
  parameter int unsigned MIN_BC    = 4
) (
  input  logic               clk_8f,
  input  logic               reset,
  partoserial_tx_if.slave    par,
  output logic               data_out,
  output logic               trained,
  output logic               word_start,
  output logic               idle_out
);

  typedef enum logic {
    TRAIN  = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  localparam logic [3:0] MIN_BC_W = 4'(MIN_BC);

  state_t     state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] next_word;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [3:0] bc_cnt_q, bc_cnt_d;
  logic       dout_d;
  logic       idle_d;
  logic       load;
  logic       take;

  // bit_cnt==7 marks the last bit of a word: the slot for the next one
  assign load          = (bit_cnt_q == 3'd7);
  assign trained       = (state_q == ACTIVE);
  assign word_start    = (bit_cnt_q == 3'd0);
  assign par.ready_par = trained && load;
  assign take          = par.ready_par && par.valid_par;

  always_ff @(posedge clk_8f or posedge reset) begin
    if (reset) begin
      state_q   <= TRAIN;
      shift_q   <= 8'h00;
      bit_cnt_q <= 3'd7;
      bc_cnt_q  <= 4'd0;
      data_out  <= 1'b0;
      idle_out  <= 1'b1;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      bc_cnt_q  <= bc_cnt_d;
      data_out  <= dout_d;
      idle_out  <= idle_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = {shift_q[6:0], 1'b0};
    bit_cnt_d = bit_cnt_q + 3'd1;
    bc_cnt_d  = bc_cnt_q;
    dout_d    = shift_q[7];
    idle_d    = idle_out;
    next_word = take ? par.data_par : IDLE_WORD;
    if (load) begin
      dout_d    = next_word[7];
      shift_d   = {next_word[6:0], 1'b0};
      bit_cnt_d = 3'd0;
      idle_d    = !take;
      unique case (state_q)
        TRAIN: begin
          bc_cnt_d = bc_cnt_q + 4'd1;
          if (bc_cnt_d == MIN_BC_W)
            state_d = ACTIVE;
        end
        ACTIVE: begin
          if (bc_cnt_q != 4'hF)
            bc_cnt_d = bc_cnt_q + 4'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_partoserial_tx.sv
// Randomised bench for partoserial_tx against a slot-level stream model
// and a behavioural comma-locking receiver fed from data_out.
module tb_partoserial_tx;
  localparam logic [7:0] BC  = 8'hBC;
  localparam int         NBC = 4;

  logic clk_8f = 1'b0;
  logic reset  = 1'b1;
  logic data_out, trained, word_start, idle_out;

  partoserial_tx_if par ();

  partoserial_tx #(
    .IDLE_WORD(BC),
    .MIN_BC   (NBC)
  ) dut (
    .clk_8f    (clk_8f),
    .reset     (reset),
    .par       (par.slave),
    .data_out  (data_out),
    .trained   (trained),
    .word_start(word_start),
    .idle_out  (idle_out)
  );

  always #5 clk_8f = ~clk_8f;

  int tests = 0;
  int fails = 0;

  // model: t counts edges since reset release; word slot n starts at edge 8n+1
  int         t;
  logic [7:0] m_word;
  logic       m_idle;
  logic       m_acc;
  logic [7:0] acc_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] rx_sr;
  logic       rx_align;
  int         rx_pos;
  int         rx_bc;

  function automatic logic exp_dout();
    int b;
    if (t == 0) return 1'b0;
    b = 7 - ((t - 1) % 8);
    return m_word[b];
  endfunction

  function automatic logic exp_ready();
    return (t > 0) && (t % 8 == 0) && (t >= 8 * NBC);
  endfunction

  function automatic logic exp_trained();
    return t >= 8 * (NBC - 1) + 1;
  endfunction

  function automatic logic exp_ws();
    return (t > 0) && ((t - 1) % 8 == 0);
  endfunction

  task automatic model_reset();
    t        = 0;
    m_word   = 8'h00;
    m_idle   = 1'b1;
    m_acc    = 1'b0;
    rx_sr    = 8'h00;
    rx_align = 1'b0;
    rx_pos   = 0;
    rx_bc    = 0;
    acc_q.delete();
    rx_q.delete();
  endtask

  task automatic rx_feed(input logic b);
    rx_sr = {rx_sr[6:0], b};
    if (!rx_align) begin
      if (rx_sr == BC) begin
        rx_align = 1'b1;
        rx_pos   = 0;
        rx_bc    = 1;
      end
    end else begin
      rx_pos++;
      if (rx_pos == 8) begin
        rx_pos = 0;
        if (rx_bc < NBC) begin
          if (rx_sr == BC) rx_bc++;
        end else if (rx_sr != BC) begin
          rx_q.push_back(rx_sr);
        end
      end
    end
  endtask

  task automatic tick();
    logic       v;
    logic [7:0] d;
    v = par.valid_par;
    d = par.data_par;
    @(posedge clk_8f);
    t++;
    m_acc = 1'b0;
    if ((t - 1) % 8 == 0) begin
      m_acc  = ((t - 1) / 8 >= NBC) && v;
      m_word = m_acc ? d : BC;
      m_idle = !m_acc;
      if (m_acc) acc_q.push_back(d);
    end
    #1;
    rx_feed(data_out);
  endtask

  task automatic release_reset();
    @(negedge clk_8f);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    par.valid_par = 1'b0;
    par.data_par  = 8'h00;
    reset = 1'b1;
    repeat (2) @(posedge clk_8f);
    #1;
    tests++;
    if (data_out !== 1'b0 || trained !== 1'b0 || idle_out !== 1'b1) begin
      fails++;
      $display("FAIL reset_outs dout=%b trained=%b idle=%b exp 0 0 1",
               data_out, trained, idle_out);
    end
    tests++;
    if (par.ready_par !== 1'b0 || word_start !== 1'b0) begin
      fails++;
      $display("FAIL reset_hs ready=%b ws=%b exp 0 0",
               par.ready_par, word_start);
    end
    release_reset();
  endtask

  task automatic test_training();
    logic [7:0] pat;
    int         b;
    pat = BC;
    par.valid_par = 1'b0;
    for (int i = 1; i <= 32; i++) begin
      tick();
      b = 7 - ((i - 1) % 8);
      tests++;
      if (data_out !== pat[b] || data_out !== exp_dout()) begin
        fails++;
        $display("FAIL train_dout t=%0d got %b exp %b", t, data_out, pat[b]);
      end
      tests++;
      if (trained !== exp_trained() || par.ready_par !== exp_ready()) begin
        fails++;
        $display("FAIL train_ctl t=%0d trained=%b ready=%b exp %b %b",
                 t, trained, par.ready_par, exp_trained(), exp_ready());
      end
      tests++;
      if (word_start !== exp_ws() || idle_out !== 1'b1) begin
        fails++;
        $display("FAIL train_ws t=%0d ws=%b idle=%b exp %b 1",
                 t, word_start, idle_out, exp_ws());
      end
    end
  endtask

  task automatic test_single();
    logic [7:0] w1, w2;
    logic       idle1, idle2;
    par.data_par  = 8'hA5;
    par.valid_par = 1'b1;
    w1 = 8'h00;
    w2 = 8'h00;
    idle1 = 1'b1;
    idle2 = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (m_acc) par.valid_par = 1'b0;
      if (i <= 8) w1 = {w1[6:0], data_out};
      else        w2 = {w2[6:0], data_out};
      if (i == 1) idle1 = idle_out;
      if (i == 9) idle2 = idle_out;
      tests++;
      if (data_out !== exp_dout() || par.ready_par !== exp_ready()) begin
        fails++;
        $display("FAIL single_bit t=%0d dout=%b ready=%b exp %b %b",
                 t, data_out, par.ready_par, exp_dout(), exp_ready());
      end
    end
    tests++;
    if (w1 !== 8'hA5 || idle1 !== 1'b0) begin
      fails++;
      $display("FAIL single_word got %h idle=%b exp a5 0", w1, idle1);
    end
    tests++;
    if (w2 !== BC || idle2 !== 1'b1) begin
      fails++;
      $display("FAIL single_fill got %h idle=%b exp bc 1", w2, idle2);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  words[3];
    logic [23:0] stream;
    int          idx;
    int          pulses;
    words  = '{8'h01, 8'hFF, 8'h3C};
    idx    = 0;
    pulses = 0;
    stream = 24'h0;
    par.data_par  = words[0];
    par.valid_par = 1'b1;
    for (int i = 1; i <= 24; i++) begin
      tick();
      if (m_acc) begin
        idx++;
        if (idx < 3) par.data_par = words[idx];
        else         par.valid_par = 1'b0;
      end
      stream = {stream[22:0], data_out};
      if (par.ready_par === 1'b1) pulses++;
      tests++;
      if (idle_out !== m_idle || par.ready_par !== exp_ready()) begin
        fails++;
        $display("FAIL b2b_ctl t=%0d idle=%b ready=%b exp %b %b",
                 t, idle_out, par.ready_par, m_idle, exp_ready());
      end
    end
    tests++;
    if (stream !== 24'h01FF3C) begin
      fails++;
      $display("FAIL b2b_stream got %h exp 01ff3c", stream);
    end
    tests++;
    if (pulses != 3) begin
      fails++;
      $display("FAIL b2b_ready_pulses got %0d exp 3", pulses);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] w;
    logic       bad_train;
    int         guard;
    par.data_par  = 8'hC3;
    par.valid_par = 1'b1;
    guard = 0;
    do begin
      tick();
      guard++;
    end while (!m_acc && guard < 40);
    par.valid_par = 1'b0;
    repeat (4) tick();
    #1;
    reset = 1'b1;
    #1;
    tests++;
    if (data_out !== 1'b0 || trained !== 1'b0 || par.ready_par !== 1'b0) begin
      fails++;
      $display("FAIL midreset_async dout=%b trained=%b ready=%b exp 0 0 0",
               data_out, trained, par.ready_par);
    end
    repeat (2) @(posedge clk_8f);
    release_reset();
    par.data_par  = 8'h5A;
    par.valid_par = 1'b1;
    bad_train = 1'b0;
    w = 8'h00;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (m_acc) par.valid_par = 1'b0;
      if (i <= 32 && idle_out !== 1'b1) bad_train = 1'b1;
      if (i > 32) w = {w[6:0], data_out};
      tests++;
      if (data_out !== exp_dout()) begin
        fails++;
        $display("FAIL midreset_dout t=%0d got %b exp %b",
                 t, data_out, exp_dout());
      end
    end
    tests++;
    if (bad_train || w !== 8'h5A) begin
      fails++;
      $display("FAIL midreset_retrain word=%h idle_bad=%b exp 5a 0",
               w, bad_train);
    end
  endtask

  task automatic test_loopback();
    logic [7:0] nxt;
    int         guard;
    reset = 1'b1;
    @(posedge clk_8f);
    release_reset();
    nxt = 8'h11;
    par.data_par  = nxt;
    par.valid_par = 1'b1;
    guard = 0;
    while (rx_q.size() < 16 && guard < 400) begin
      tick();
      guard++;
      if (m_acc) begin
        nxt = nxt + 8'h01;
        if (nxt <= 8'h20) par.data_par = nxt;
        else              par.valid_par = 1'b0;
      end
      tests++;
      if (data_out !== exp_dout()) begin
        fails++;
        $display("FAIL loop_dout t=%0d got %b exp %b", t, data_out, exp_dout());
      end
    end
    par.valid_par = 1'b0;
    tests++;
    if (rx_q.size() != 16) begin
      fails++;
      $display("FAIL loop_count got %0d exp 16", rx_q.size());
    end
    for (int i = 0; i < rx_q.size() && i < 16; i++) begin
      tests++;
      if (rx_q[i] !== 8'(8'h11 + i)) begin
        fails++;
        $display("FAIL loop_word[%0d] got %h exp %h", i, rx_q[i], 8'h11 + i);
      end
    end
  endtask

  task automatic test_toggle();
    logic [7:0] pend;
    int         n_acc;
    int         guard;
    n_acc = 0;
    guard = 0;
    do pend = 8'($urandom); while (pend == BC);
    while (n_acc < 20 && guard < 2000) begin
      par.valid_par = 1'($urandom_range(0, 1));
      par.data_par  = par.valid_par ? pend : 8'($urandom);
      tick();
      guard++;
      if (m_acc) begin
        n_acc++;
        do pend = 8'($urandom); while (pend == BC);
      end
      tests++;
      if (data_out !== exp_dout() || idle_out !== m_idle) begin
        fails++;
        $display("FAIL toggle_bit t=%0d dout=%b idle=%b exp %b %b",
                 t, data_out, idle_out, exp_dout(), m_idle);
      end
    end
    par.valid_par = 1'b0;
    repeat (16) tick();
    tests++;
    if (n_acc != 20 || rx_q.size() != acc_q.size()) begin
      fails++;
      $display("FAIL toggle_count acc=%0d rx=%0d model=%0d exp 20 and equal",
               n_acc, rx_q.size(), acc_q.size());
    end
    for (int i = 0; i < rx_q.size() && i < acc_q.size(); i++) begin
      tests++;
      if (rx_q[i] !== acc_q[i]) begin
        fails++;
        $display("FAIL toggle_word[%0d] got %h exp %h", i, rx_q[i], acc_q[i]);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_training();
    test_single();
    test_back_to_back();
    test_reset_mid();
    test_loopback();
    test_toggle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
